uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_HALF_BIT, default 53, clock cycles per half bit period; legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, minimum 2.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ser_rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port out_data  output  DATA_BITS  FIFO head data.
REQ-009 SHALL have port out_frame_err  output  1  FIFO head stop bit sampled low.
REQ-010 SHALL have port out_parity_err  output  1  FIFO head parity mismatch; 0 when PARITY=0.
REQ-011 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port out_ready  input  1  consumer pop request.
REQ-013 SHALL have port count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
REQ-014 SHALL have port overflow  output  1  sticky: a frame was dropped because FIFO was full.
REQ-015 SHALL have port overflow_clr  input  1  clears overflow.

Function
REQ-016 SHALL pass ser_rx through a 2-flop synchronizer; all receiver logic uses the synchronized value (rxs).
REQ-017 SHALL implement states IDLE, START, DATA, PAR, STOP with one shared bit-timing counter.
REQ-018 IDLE: falling edge of rxs (previous 1, current 0) -> START, counter loaded for CLKS_PER_HALF_BIT cycles.
REQ-019 START: at half-bit expiry sample rxs; 0 -> DATA with counter loaded for 2*CLKS_PER_HALF_BIT; 1 -> IDLE, nothing pushed (glitch reject).
REQ-020 DATA: sample rxs every 2*CLKS_PER_HALF_BIT cycles, LSB first; after DATA_BITS samples -> PAR if PARITY!=0, else STOP.
REQ-021 PAR: sample one bit; parity_err = received bit differs from required odd/even parity over the data bits.
REQ-022 STOP: sample one bit; frame_err = sampled value is 0; push {parity_err, frame_err, data} to FIFO in the same cycle; -> IDLE next cycle.
REQ-023 Line held low through STOP (break) SHALL push one frame with frame_err=1; no further frame until rxs returns high and falls again.
REQ-024 FIFO: out_* present head entry combinationally from storage; pop when out_valid && out_ready.
REQ-025 Push to full FIFO with no simultaneous pop SHALL drop the frame, leave contents and count unchanged, set overflow.
REQ-026 Push and pop in the same cycle SHALL both succeed, including when full; count unchanged.
REQ-027 Pop when empty SHALL be ignored.
REQ-028 Pushed frame SHALL appear at out_valid the cycle after the STOP sample (1-cycle latency when FIFO empty).
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-030 overflow_clr and an overflow-setting drop in the same cycle: overflow SHALL remain 1.

Reset
REQ-031 rst SHALL force state IDLE, counter 0, synchronizer flops and edge register to 1, FIFO pointers 0.
REQ-032 While and after rst: out_valid=0, count=0, overflow=0; out_data, out_frame_err, out_parity_err=0.
REQ-033 rst mid-frame SHALL abandon the frame without pushing; a falling edge after rst deasserts starts a new frame.

Verification
REQ-034 Defaults, send 0x41 with 1 stop bit, out_ready=1 -> single out_valid pulse, out_data=0x41, both error flags 0, within 1008..1012 cycles of pin start edge.
REQ-035 PARITY=2, send 0x03 with parity bit 1 -> out_data=0x03, out_parity_err=1; same with parity bit 0 -> out_parity_err=0.
REQ-036 ser_rx low for 20 cycles then high -> no push, count stays 0, state back to IDLE.
REQ-037 out_ready=0, send 17 frames 0x00..0x10 -> count=16, overflow=1, pops return 0x00..0x0F in order; overflow_clr pulse -> overflow=0.
REQ-038 Send 0x55 with stop bit driven 0 -> out_data=0x55, out_frame_err=1; then rxs high and frame 0xAA -> out_data=0xAA, out_frame_err=0.
REQ-039 rst asserted 1 cycle at mid-DATA of a frame with 3 entries queued -> count=0, out_valid=0, next full frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1-style, optional parity) feeding a small receive FIFO.
// The serial input is synchronised, then sampled at mid-bit using one shared counter.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_HALF_BIT = 53,
    parameter int unsigned DATA_BITS         = 8,
    parameter int unsigned PARITY            = 0,
    parameter int unsigned FIFO_DEPTH        = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ser_rx,
    output logic [DATA_BITS-1:0]              out_data,
    output logic                              out_frame_err,
    output logic                              out_parity_err,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              overflow,
    input  logic                              overflow_clr
);

    localparam int unsigned CntW   = $clog2(2 * CLKS_PER_HALF_BIT);
    localparam int unsigned BitW   = $clog2(DATA_BITS);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EntryW = DATA_BITS + 2;

    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(2 * CLKS_PER_HALF_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    // Synchroniser and edge register
    logic sync1_q, rxs_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= ser_rx;
            rxs_q   <= sync1_q;
            prev_q  <= rxs_q;
        end
    end

    logic fall;
    assign fall = prev_q & ~rxs_q;

    // Receiver FSM
    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   tick, par_req;
    logic                   push;
    logic [EntryW-1:0]      push_entry;

    assign tick    = (cnt_q == '0);
    assign par_req = (PARITY == 1) ? ~^shift_q : ^shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                end
            end
            StStart: begin
                if (tick) begin
                    if (!rxs_q) begin
                        state_d = StData;
                        cnt_d   = FullLoad;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FullLoad;
                    if (bit_q == BitW'(DATA_BITS - 1)) begin
                        state_d = (PARITY != 0) ? StPar : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StPar: begin
                if (tick) begin
                    perr_d  = rxs_q ^ par_req;
                    cnt_d   = FullLoad;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        push       = (state_q == StStop) && tick;
        push_entry = {perr_q, ~rxs_q, shift_q};
    end

    // Receive FIFO
    logic [EntryW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CountW-1:0] count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full, pop, push_ok, drop;
    logic [EntryW-1:0] head;

    assign full    = (count_q == CountW'(FIFO_DEPTH));
    assign pop     = out_valid && out_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_comb begin
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear wins so the loss is never hidden
        ovf_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_entry;
        end
    end

    assign head           = mem_q[rd_q];
    assign out_valid      = (count_q != '0);
    assign out_data       = out_valid ? head[DATA_BITS-1:0] : '0;
    assign out_frame_err  = out_valid ? head[DATA_BITS] : 1'b0;
    assign out_parity_err = out_valid ? head[DATA_BITS+1] : 1'b0;
    assign count          = count_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: default receiver (A) plus an even-parity, depth-2, fast-baud receiver (B).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_a = 1'b1, ser_b = 1'b1;
    logic       rdy_a = 1'b0, rdy_b = 1'b0;
    logic       clr_a = 1'b0, clr_b = 1'b0;

    logic [7:0] da, db;
    logic       fea, pea, va, ova;
    logic       feb, peb, vb, ovb;
    logic [4:0] cnt_a;
    logic [1:0] cnt_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut_a (
        .clk            (clk),
        .rst            (rst),
        .ser_rx         (ser_a),
        .out_data       (da),
        .out_frame_err  (fea),
        .out_parity_err (pea),
        .out_valid      (va),
        .out_ready      (rdy_a),
        .count          (cnt_a),
        .overflow       (ova),
        .overflow_clr   (clr_a)
    );

    uart_rx_fifo #(
        .CLKS_PER_HALF_BIT (8),
        .DATA_BITS         (8),
        .PARITY            (2),
        .FIFO_DEPTH        (2)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .ser_rx         (ser_b),
        .out_data       (db),
        .out_frame_err  (feb),
        .out_parity_err (peb),
        .out_valid      (vb),
        .out_ready      (rdy_b),
        .count          (cnt_b),
        .overflow       (ovb),
        .overflow_clr   (clr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int line, input logic v);
        if (line == 0) ser_a = v;
        else ser_b = v;
    endtask

    // Caller must be at a negedge; returns at a negedge after the stop bit.
    task automatic send(input int line, input int half, input logic [7:0] data,
                        input bit has_par, input logic par_bit, input logic stop_bit);
        drive(line, 1'b0);
        hold(2 * half);
        for (int i = 0; i < 8; i++) begin
            drive(line, data[i]);
            hold(2 * half);
        end
        if (has_par) begin
            drive(line, par_bit);
            hold(2 * half);
        end
        drive(line, stop_bit);
        hold(2 * half);
    endtask

    task automatic pop_a();
        rdy_a = 1'b1;
        hold(1);
        rdy_a = 1'b0;
    endtask

    task automatic pop_b();
        rdy_b = 1'b1;
        hold(1);
        rdy_b = 1'b0;
    endtask

    int         lat;
    logic       got, v_next, cap_fe, cap_pe;
    logic [7:0] cap_d;

    initial begin
        hold(4);
        check("rst_valid_a", va, 0);
        check("rst_count_a", cnt_a, 0);
        check("rst_ovf_a", ova, 0);
        check("rst_data_a", da, 0);
        check("rst_fe_a", fea, 0);
        check("rst_pe_a", pea, 0);
        check("rst_valid_b", vb, 0);
        check("rst_count_b", cnt_b, 0);
        rst = 1'b0;
        hold(4);

        // Single frame 0x41, consumer always ready: one-cycle valid pulse
        rdy_a = 1'b1;
        got = 1'b0;
        lat = 0;
        v_next = 1'b1;
        fork
            send(0, 53, 8'h41, 1'b0, 1'b0, 1'b1);
            begin
                for (int n = 1; n <= 1200; n++) begin
                    @(posedge clk);
                    #1;
                    if (va) begin
                        lat = n;
                        got = 1'b1;
                        cap_d = da;
                        cap_fe = fea;
                        cap_pe = pea;
                        break;
                    end
                end
                @(posedge clk);
                #1;
                v_next = va;
            end
        join
        rdy_a = 1'b0;
        check("x41_seen", got, 1);
        check("x41_latency_window", (lat >= 1008 && lat <= 1012), 1);
        check("x41_data", cap_d, 8'h41);
        check("x41_fe", cap_fe, 0);
        check("x41_pe", cap_pe, 0);
        check("x41_single_pulse", v_next, 0);
        check("x41_count_after", cnt_a, 0);

        // Short low glitch is rejected
        drive(0, 1'b0);
        hold(20);
        drive(0, 1'b1);
        hold(300);
        check("glitch_count", cnt_a, 0);
        check("glitch_valid", va, 0);

        // Break: stop bit low and line kept low yields exactly one frame
        send(0, 53, 8'h55, 1'b0, 1'b0, 1'b0);
        hold(300);
        drive(0, 1'b1);
        hold(20);
        check("brk_count", cnt_a, 1);
        check("brk_data", da, 8'h55);
        check("brk_fe", fea, 1);
        check("brk_pe", pea, 0);
        pop_a();
        check("brk_popped", cnt_a, 0);
        send(0, 53, 8'hAA, 1'b0, 1'b0, 1'b1);
        hold(4);
        check("xaa_valid", va, 1);
        check("xaa_data", da, 8'hAA);
        check("xaa_fe", fea, 0);
        pop_a();

        // Overflow: 17 frames into a 16-entry FIFO
        for (int i = 0; i <= 16; i++) begin
            send(0, 53, 8'(i), 1'b0, 1'b0, 1'b1);
        end
        hold(4);
        check("ovf_count", cnt_a, 16);
        check("ovf_flag", ova, 1);
        rdy_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_pop%0d", i), da, 32'(i));
            hold(1);
        end
        rdy_a = 1'b0;
        check("ovf_drained_count", cnt_a, 0);
        check("ovf_drained_valid", va, 0);
        check("ovf_sticky", ova, 1);
        pop_a();
        check("pop_empty_count", cnt_a, 0);
        clr_a = 1'b1;
        hold(1);
        clr_a = 1'b0;
        check("ovf_cleared", ova, 0);

        // Reset in the middle of a data bit with three entries queued
        send(0, 53, 8'h11, 1'b0, 1'b0, 1'b1);
        send(0, 53, 8'h22, 1'b0, 1'b0, 1'b1);
        send(0, 53, 8'h33, 1'b0, 1'b0, 1'b1);
        check("pre_rst_count", cnt_a, 3);
        fork
            send(0, 53, 8'hF0, 1'b0, 1'b0, 1'b1);
            begin
                hold(690);
                rst = 1'b1;
                hold(1);
                rst = 1'b0;
            end
        join
        hold(4);
        check("midrst_count", cnt_a, 0);
        check("midrst_valid", va, 0);
        send(0, 53, 8'h7E, 1'b0, 1'b0, 1'b1);
        hold(4);
        check("x7e_valid", va, 1);
        check("x7e_data", da, 8'h7E);
        check("x7e_fe", fea, 0);
        check("x7e_count", cnt_a, 1);
        pop_a();

        // Even parity on receiver B
        send(1, 8, 8'h03, 1'b1, 1'b1, 1'b1);
        hold(4);
        check("par1_valid", vb, 1);
        check("par1_data", db, 8'h03);
        check("par1_pe", peb, 1);
        check("par1_fe", feb, 0);
        pop_b();
        send(1, 8, 8'h03, 1'b1, 1'b0, 1'b1);
        hold(4);
        check("par0_data", db, 8'h03);
        check("par0_pe", peb, 0);
        pop_b();

        // Depth-2 overflow keeps contents
        send(1, 8, 8'h01, 1'b1, 1'b1, 1'b1);
        send(1, 8, 8'h02, 1'b1, 1'b1, 1'b1);
        check("b_full_count", cnt_b, 2);
        check("b_no_ovf_yet", ovb, 0);
        send(1, 8, 8'h04, 1'b1, 1'b1, 1'b1);
        hold(4);
        check("b_ovf_flag", ovb, 1);
        check("b_ovf_count", cnt_b, 2);
        check("b_ovf_head", db, 8'h01);
        pop_b();
        check("b_second", db, 8'h02);
        pop_b();
        check("b_empty", vb, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
